// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with hex / sequential double-dabble decimal load path.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
//
// state    | meaning
// ST_IDLE  | waiting for load_in
// ST_HEX   | hex value captured, commit on this edge
// ST_START | decimal value captured, clear converter and raise busy_out
// ST_CONV  | one double-dabble step per cycle, commit on the last step
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS    = 4,
    parameter int VALUE_WIDTH   = 14,
    parameter int SCAN_DIV_LOG2 = 17
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [VALUE_WIDTH-1:0] value_in,
    input  logic                   load_in,
    input  logic                   hex_mode_in,
    output logic                   busy_out,
    output logic [NUM_DIGITS-1:0]  an_out,
    output logic [6:0]             seg_out
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(VALUE_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEX,
        ST_START,
        ST_CONV
    } state_t;

    state_t                   state;
    logic [SCAN_DIV_LOG2-1:0] scan_cnt;
    logic [IDX_W-1:0]         digit_idx;
    logic [DW-1:0]            digits;
    logic                     ovf;
    logic [VALUE_WIDTH-1:0]   val_cap;
    logic [DW-1:0]            bcd;
    logic                     bcd_ovf;
    logic [CNT_W-1:0]         step_cnt;

    logic [DW-1:0]            adj;
    logic [DW-1:0]            bcd_next;
    logic                     bcd_carry;
    logic [DW-1:0]            hex_dig;
    logic                     hex_ovf;
    logic [3:0]               cur_dig;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            if (&scan_cnt) begin
                if (digit_idx == IDX_W'(NUM_DIGITS - 1))
                    digit_idx <= '0;
                else
                    digit_idx <= digit_idx + 1'b1;
            end
        end
    end

    generate
        if (VALUE_WIDTH > DW) begin : g_hex_wide
            assign hex_dig = val_cap[DW-1:0];
            assign hex_ovf = |val_cap[VALUE_WIDTH-1:DW];
        end else begin : g_hex_narrow
            assign hex_dig = DW'(val_cap);
            assign hex_ovf = 1'b0;
        end
    endgenerate

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // A bit carried out of the top digit means the value needs more digits than we have.
    assign bcd_carry = adj[DW-1];
    assign bcd_next  = {adj[DW-2:0], val_cap[VALUE_WIDTH-1]};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= ST_IDLE;
            busy_out <= 1'b0;
            digits   <= '0;
            ovf      <= 1'b0;
            val_cap  <= '0;
            bcd      <= '0;
            bcd_ovf  <= 1'b0;
            step_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_in) begin
                        val_cap <= value_in;
                        state   <= hex_mode_in ? ST_HEX : ST_START;
                    end
                end
                ST_HEX: begin
                    digits <= hex_dig;
                    ovf    <= hex_ovf;
                    state  <= ST_IDLE;
                    if (load_in) begin
                        val_cap <= value_in;
                        state   <= hex_mode_in ? ST_HEX : ST_START;
                    end
                end
                ST_START: begin
                    // busy_out is still low here, so a new load supersedes the pending one.
                    if (load_in) begin
                        val_cap <= value_in;
                        state   <= hex_mode_in ? ST_HEX : ST_START;
                    end else begin
                        busy_out <= 1'b1;
                        bcd      <= '0;
                        bcd_ovf  <= 1'b0;
                        step_cnt <= CNT_W'(VALUE_WIDTH);
                        state    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd      <= bcd_next;
                    bcd_ovf  <= bcd_ovf | bcd_carry;
                    val_cap  <= val_cap << 1;
                    step_cnt <= step_cnt - 1'b1;
                    if (step_cnt == CNT_W'(1)) begin
                        digits   <= bcd_next;
                        ovf      <= bcd_ovf | bcd_carry;
                        busy_out <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        case (d)
            4'h0: seg7_decode = 7'b0000001;
            4'h1: seg7_decode = 7'b1001111;
            4'h2: seg7_decode = 7'b0010010;
            4'h3: seg7_decode = 7'b0000110;
            4'h4: seg7_decode = 7'b1001100;
            4'h5: seg7_decode = 7'b0100100;
            4'h6: seg7_decode = 7'b0100000;
            4'h7: seg7_decode = 7'b0001111;
            4'h8: seg7_decode = 7'b0000000;
            4'h9: seg7_decode = 7'b0000100;
            4'hA: seg7_decode = 7'b0001000;
            4'hB: seg7_decode = 7'b1100000;
            4'hC: seg7_decode = 7'b0110001;
            4'hD: seg7_decode = 7'b1000010;
            4'hE: seg7_decode = 7'b0110000;
            default: seg7_decode = 7'b0111000;
        endcase
    endfunction

    assign cur_dig = digits[int'(digit_idx)*4 +: 4];
    assign an_out  = ~(NUM_DIGITS'(1) << digit_idx);

`ifdef SEG7_LZB_EN
    logic [NUM_DIGITS-1:0] blank;
    logic                  upper_zero;

    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero & (digits[4*i +: 4] == 4'd0);
            blank[i]   = upper_zero;
        end
    end

    always_comb begin
        if (ovf)
            seg_out = 7'b1111110;
        else if (blank[digit_idx])
            seg_out = 7'b1111111;
        else
            seg_out = seg7_decode(cur_dig);
    end
`else
    always_comb begin
        if (ovf)
            seg_out = 7'b1111110;
        else
            seg_out = seg7_decode(cur_dig);
    end
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, 14-bit value, 4 clocks per slot) plus a 3-digit scan instance.
module tb_seg7_scan_ctrl;

    localparam logic [6:0] S_0    = 7'b0000001;
    localparam logic [6:0] S_1    = 7'b1001111;
    localparam logic [6:0] S_2    = 7'b0010010;
    localparam logic [6:0] S_3    = 7'b0000110;
    localparam logic [6:0] S_4    = 7'b1001100;
    localparam logic [6:0] S_5    = 7'b0100100;
    localparam logic [6:0] S_6    = 7'b0100000;
    localparam logic [6:0] S_7    = 7'b0001111;
    localparam logic [6:0] S_8    = 7'b0000000;
    localparam logic [6:0] S_F    = 7'b0111000;
    localparam logic [6:0] S_DASH = 7'b1111110;
`ifdef SEG7_LZB_EN
    localparam logic [6:0] S_LZ   = 7'b1111111;
`else
    localparam logic [6:0] S_LZ   = S_0;
`endif

    logic        clk;
    logic        rst_n;
    logic        load;
    logic        hex_mode;
    logic [13:0] value;
    logic        busy;
    logic        busy3;
    logic [3:0]  an;
    logic [2:0]  an3;
    logic [6:0]  seg;
    logic [6:0]  seg3;

    int          errors = 0;
    int          checks = 0;
    int          cyc;
    int          n;
    logic [6:0]  exp_seg [4];

    seg7_scan_ctrl #(.NUM_DIGITS(4), .VALUE_WIDTH(14), .SCAN_DIV_LOG2(2)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .value_in(value), .load_in(load),
        .hex_mode_in(hex_mode), .busy_out(busy), .an_out(an), .seg_out(seg));

    seg7_scan_ctrl #(.NUM_DIGITS(3), .VALUE_WIDTH(14), .SCAN_DIV_LOG2(2)) dut3 (
        .clk_in(clk), .rst_n_in(rst_n), .value_in(value), .load_in(load),
        .hex_mode_in(hex_mode), .busy_out(busy3), .an_out(an3), .seg_out(seg3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks since reset release; slot index is cyc/4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_exp(input logic [6:0] d3, input logic [6:0] d2,
                           input logic [6:0] d1, input logic [6:0] d0);
        exp_seg[0] = d0;
        exp_seg[1] = d1;
        exp_seg[2] = d2;
        exp_seg[3] = d3;
    endtask

    task automatic check_scan();
        int         idx;
        logic [3:0] ea;
        logic [2:0] ea3;
        idx = (cyc >> 2) % 4;
        ea  = ~(4'b0001 << idx);
        ea3 = ~(3'b001 << ((cyc >> 2) % 3));
        chk("an", 32'(an), 32'(ea));
        chk("an3", 32'(an3), 32'(ea3));
        chk("seg", 32'(seg), 32'(exp_seg[idx]));
    endtask

    task automatic check_display(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            check_scan();
            chk("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    task automatic do_load(input logic [13:0] v, input logic hx);
        load     = 1'b1;
        value    = v;
        hex_mode = hx;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Counts busy cycles from n0 until busy falls; display must hold the old value meanwhile.
    task automatic run_conv(input int n0, input bit late, output int cnt);
        bit done;
        done = 1'b0;
        cnt  = n0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (busy) begin
                cnt++;
                check_scan();
                if (late && cnt == 14) begin
                    load     = 1'b1;
                    value    = 14'd9;
                    hex_mode = 1'b1;
                end
            end else begin
                done = 1'b1;
            end
        end
        chk("conv_done", 32'(done), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        hex_mode = 1'b0;
        value    = '0;
        set_exp(S_0, S_0, S_0, S_0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_an", 32'(an), 32'b1110);
        chk("rst_seg", 32'(seg), 32'(S_0));
        chk("rst_an3", 32'(an3), 32'b110);

        rst_n = 1'b1;
        check_scan();
        check_display(20);

        do_load(14'd1234, 1'b0);
        chk("busy_late_rise", 32'(busy), 32'd0);
        run_conv(0, 1'b0, n);
        chk("busy_len_1234", 32'(n), 32'd14);
        set_exp(S_1, S_2, S_3, S_4);
        check_scan();
        check_display(16);

        do_load(14'h2F3, 1'b1);
        chk("hex_busy", 32'(busy), 32'd0);
        check_scan();
        @(negedge clk);
        set_exp(S_LZ, S_2, S_F, S_3);
        check_scan();
        check_display(16);

        do_load(14'd10000, 1'b0);
        run_conv(0, 1'b0, n);
        chk("busy_len_10000", 32'(n), 32'd14);
        set_exp(S_DASH, S_DASH, S_DASH, S_DASH);
        check_scan();
        check_display(16);

        do_load(14'd7, 1'b0);
        run_conv(0, 1'b0, n);
        set_exp(S_LZ, S_LZ, S_LZ, S_7);
        check_scan();
        check_display(16);

        do_load(14'd5678, 1'b0);
        @(negedge clk);
        chk("busy_5678", 32'(busy), 32'd1);
        load     = 1'b1;
        value    = 14'd9;
        hex_mode = 1'b0;
        @(negedge clk);
        load = 1'b0;
        chk("busy_drop", 32'(busy), 32'd1);
        run_conv(2, 1'b1, n);
        chk("busy_len_5678", 32'(n), 32'd14);
        set_exp(S_5, S_6, S_7, S_8);
        check_scan();
        check_display(24);

        do_load(14'd1234, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check_scan();
        end
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        set_exp(S_0, S_0, S_0, S_0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_an", 32'(an), 32'b1110);
        chk("abort_seg", 32'(seg), 32'(S_0));
        @(negedge clk);
        rst_n = 1'b1;
        check_display(32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
